instr_decode_queue: RTL and testbench
=====================================

Name: instr_decode_queue

Overview:
- Parametrised decode stage placed between fetch and the issue/ID pipeline register.
- Decodes each incoming RV32I instruction word at enqueue: register fields, the sign-extended immediate selected by format, register-use flags and an illegal flag.
- Buffers the decoded bundles in a DEPTH-entry circular FIFO, so fetch stalls decouple from downstream stalls.
- Both sides use valid/ready handshakes; flush discards all in-flight entries.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PC_W, 32, width of the PC carried with each instruction.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all entries and any concurrent push.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept (count < DEPTH).
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  downstream accepts head.
- out_pc  out  PC_W  head PC.
- out_opcode  out  7  instr[6:0], typed rv32i_opcode.
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rs1  out  5  instr[19:15]; 0 when uses_rs1=0.
- out_rs2  out  5  instr[24:20]; 0 when uses_rs2=0.
- out_rd  out  5  instr[11:7]; 0 when writes_rd=0.
- out_imm  out  32  immediate selected by format.
- out_uses_rs1  out  1  instruction reads rs1.
- out_uses_rs2  out  1  instruction reads rs2.
- out_writes_rd  out  1  instruction writes rd.
- out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst low, async): head=tail=count=0.
  - out_valid=0; in_ready=1.
  - Storage is not cleared. Outputs are don't-care while out_valid=0; the RTL drives them from entry[head].
- Push: in_valid && in_ready && !flush. Decoded bundle is written to entry[tail]; tail <= tail+1, wrapping modulo DEPTH.
- Pop: out_valid && out_ready && !flush. head <= head+1, wrapping modulo DEPTH.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no bypass path.
- Simultaneous push and pop: count is unchanged. Legal at any count; at count==DEPTH no push occurs because in_ready=0.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- Full (count==DEPTH): in_ready=0; in_valid is ignored.
- Empty (count==0): out_valid=0; out_ready is ignored.
- Flush has priority over push and pop. Next cycle: head=tail=count=0, out_valid=0.
- Decode is combinational on in_instr; the registered copy is stored. Immediate selection by opcode:
  - lui, auipc: U-type imm = {instr[31:12], 12'h0}; rd only.
  - jal: J-type; rd only.
  - jalr, load, op_imm: I-type; rs1 and rd.
  - store: S-type; rs1 and rs2; no rd.
  - br: B-type; rs1 and rs2; no rd.
  - op (reg-reg): imm=0; rs1, rs2 and rd.
  - csr/system: I-type; rs1 and rd.
  - Anything else: illegal=1, imm=0, all use flags 0.
- rd==0 still sets writes_rd as decoded. Hazard logic handles x0.
- Illegal entries are queued and delivered in order; this block does not trap.

Decomposition:
- rv32i_types (existing package):
  - reuses rv32i_opcode;
  - adds imm_fmt_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - adds decoded_instr_t struct covering pc, opcode, funct3, funct7, rs1, rs2, rd, imm, the three use flags and illegal.
- One natural sub-module: instr_field_decode. Purely combinational: instr in, decoded_instr_t out. The queue instantiates it on the push side and stores the struct in an array of DEPTH entries.

Test Plan:
- Reset, then push addi x1,x2,5 (0x00510093, pc 0x40) -> next cycle: out_valid=1, opcode 0x13, rd=1, rs1=2, rs2=0, imm=0x00000005, uses_rs2=0, count=1.
- Push lui x5,0x12345 (0x123452B7); beq x1,x2,-4 (0xFE208EE3); sw x2,8(x1) (0x0020A423); out_ready=1 -> in order:
  - lui: imm 0x12345000, rd=5.
  - beq: imm 0xFFFFFFFC, writes_rd=0, rd=0.
  - sw: imm 0x00000008, rs2=2, writes_rd=0.
- DEPTH=4, out_ready=0, push 6 words -> in_ready drops after 4th push, count=4. Then out_ready=1 -> entries pop in order and wrap; total 6 delivered, none lost or duplicated.
- At count=4, raise out_ready and in_valid together over 8 cycles -> count oscillates 3..4, order preserved across the head/tail wrap.
- At count=3, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0; the flushed push never appears.
- Push 0x00000000 and 0xFFFFFFFF -> both delivered with out_illegal=1 and all use flags 0. Assert rst low mid-stream -> out_valid=0 immediately, count=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: base opcodes, immediate formats and the decoded
// instruction bundle carried from fetch to issue.
package rv32i_types;

  // Widest PC the decoded bundle can carry; narrower PCs are zero-extended.
  localparam int PC_MAX_W = 32;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BR     = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } rv32i_opcode;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    rv32i_opcode         opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } decoded_instr_t;

  // Assemble the sign-extended immediate for a given instruction format.
  function automatic logic [31:0] imm_extract(input logic [31:0] instr,
                                              input imm_fmt_t    fmt);
    logic [31:0] imm;
    imm = 32'h0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decode_queue_field_decode.sv
// Combinational RV32I field decoder: splits an instruction word into register
// fields, usage flags and the format-selected immediate. The pc field is left
// zero; the queue fills it in from the fetch side.
module instr_field_decode
  import rv32i_types::*;
(
  input  logic [31:0]    i_instr,
  output decoded_instr_t o_dec
);

  imm_fmt_t w_fmt;
  logic     w_uses_rs1;
  logic     w_uses_rs2;
  logic     w_writes_rd;
  logic     w_known;

  // Classify the opcode into an immediate format and register-use pattern.
  always_comb begin
    w_fmt       = IMM_NONE;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    w_known     = 1'b1;
    case (i_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_fmt       = IMM_U;
        w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_fmt       = IMM_J;
        w_writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        w_fmt       = IMM_I;
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_STORE: begin
        w_fmt      = IMM_S;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_BR: begin
        w_fmt      = IMM_B;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        w_fmt       = IMM_NONE;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b1;
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  // Build the bundle; unused register fields are forced to zero so downstream
  // hazard logic never sees stale operand numbers.
  always_comb begin
    o_dec           = '0;
    o_dec.opcode    = rv32i_opcode'(i_instr[6:0]);
    o_dec.funct3    = i_instr[14:12];
    o_dec.funct7    = i_instr[31:25];
    o_dec.uses_rs1  = w_uses_rs1;
    o_dec.uses_rs2  = w_uses_rs2;
    o_dec.writes_rd = w_writes_rd;
    o_dec.rs1       = w_uses_rs1  ? i_instr[19:15] : 5'd0;
    o_dec.rs2       = w_uses_rs2  ? i_instr[24:20] : 5'd0;
    o_dec.rd        = w_writes_rd ? i_instr[11:7]  : 5'd0;
    o_dec.imm       = imm_extract(i_instr, w_fmt);
    o_dec.illegal   = !w_known || (i_instr[1:0] != 2'b11);
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Decode stage between fetch and issue: decodes each RV32I word on enqueue and
// buffers the decoded bundles in a DEPTH-entry circular FIFO with valid/ready
// handshakes on both sides and a flush that empties everything.
module instr_decode_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output rv32i_opcode      out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic             out_uses_rs1,
  output logic             out_uses_rs2,
  output logic             out_writes_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  decoded_instr_t   r_mem [DEPTH];

  decoded_instr_t   w_dec;
  decoded_instr_t   w_entry;
  decoded_instr_t   w_head;
  logic             w_push;
  logic             w_pop;

  instr_field_decode u_decode (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Ready/valid come straight from the registered count, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;

  // Attach the fetch PC to the decoded fields before storing.
  always_comb begin
    w_entry    = w_dec;
    w_entry.pc = PC_MAX_W'(in_pc);
  end

  // Pointer and occupancy bookkeeping; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is data only and is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  // Head entry drives the outputs unconditionally; they are meaningful only
  // while out_valid is high.
  always_comb begin
    w_head        = r_mem[r_head];
    out_pc        = PC_W'(w_head.pc);
    out_opcode    = w_head.opcode;
    out_funct3    = w_head.funct3;
    out_funct7    = w_head.funct7;
    out_rs1       = w_head.rs1;
    out_rs2       = w_head.rs2;
    out_rd        = w_head.rd;
    out_imm       = w_head.imm;
    out_uses_rs1  = w_head.uses_rs1;
    out_uses_rs2  = w_head.uses_rs2;
    out_writes_rd = w_head.writes_rd;
    out_illegal   = w_head.illegal;
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed steps plus randomized traffic checked
// against a queue-based reference model and a spec-level decoder.
module tb_instr_decode_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             in_ready, out_valid;
  logic [PC_W-1:0]  out_pc;
  rv32i_opcode      out_opcode;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [31:0]      out_imm;
  logic             out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  logic [CNT_W-1:0] count;

  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        u1, u2, wr, ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;

  // Reference decoder: pick a format letter per opcode, then build fields.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t       e;
    logic [7:0] fmt;
    e.pc = pc; e.op = w[6:0]; e.f3 = w[14:12]; e.f7 = w[31:25];
    e.u1 = 0; e.u2 = 0; e.wr = 0; e.ill = 0; fmt = "N";
    case (w[6:0])
      7'h37, 7'h17:               begin fmt = "U"; e.wr = 1; end
      7'h6F:                      begin fmt = "J"; e.wr = 1; end
      7'h67, 7'h03, 7'h13, 7'h73: begin fmt = "I"; e.u1 = 1; e.wr = 1; end
      7'h23:                      begin fmt = "S"; e.u1 = 1; e.u2 = 1; end
      7'h63:                      begin fmt = "B"; e.u1 = 1; e.u2 = 1; end
      7'h33:                      begin e.u1 = 1; e.u2 = 1; e.wr = 1; end
      default:                    e.ill = 1;
    endcase
    if (w[1:0] != 2'b11) e.ill = 1;
    case (fmt)
      "I":     e.imm = 32'($signed(w[31:20]));
      "S":     e.imm = 32'($signed({w[31:25], w[11:7]}));
      "B":     e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      "U":     e.imm = w[31:12] * 32'd4096;
      "J":     e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: e.imm = 32'd0;
    endcase
    e.rs1 = e.u1 ? w[19:15] : 5'd0;
    e.rs2 = e.u2 ? w[24:20] : 5'd0;
    e.rd  = e.wr ? w[11:7]  : 5'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      chk("pc", 64'(out_pc), 64'(q[0].pc));
      chk("opcode", 64'(out_opcode), 64'(q[0].op));
      chk("funct3", 64'(out_funct3), 64'(q[0].f3));
      chk("funct7", 64'(out_funct7), 64'(q[0].f7));
      chk("rs1", 64'(out_rs1), 64'(q[0].rs1));
      chk("rs2", 64'(out_rs2), 64'(q[0].rs2));
      chk("rd", 64'(out_rd), 64'(q[0].rd));
      chk("imm", 64'(out_imm), 64'(q[0].imm));
      chk("flags", 64'({out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}),
          64'({q[0].u1, q[0].u2, q[0].wr, q[0].ill}));
    end
  endtask

  // One clock: predict handshakes from current inputs, advance model, check.
  task automatic cyc();
    bit   push, pop;
    exp_t e;
    push = in_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    e    = model(in_instr, 32'(in_pc));
    @(posedge clk); #1;
    if (flush) q.delete();
    else begin
      if (pop) begin void'(q.pop_front()); delivered++; end
      if (push) q.push_back(e);
    end
    check_state();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    int          k;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) r[6:0] = ops[k];
    else if (k == 11) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    logic [31:0] words [6];
    int          k, guard;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk); #1; rst = 1'b1;

    // addi x1,x2,5
    in_valid = 1; in_instr = 32'h00510093; in_pc = 32'h40;
    cyc();
    in_valid = 0;
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_op", 64'(out_opcode), 64'h13);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_rs1", 64'(out_rs1), 64'd2);
    chk("addi_rs2", 64'(out_rs2), 64'd0);
    chk("addi_imm", 64'(out_imm), 64'h5);
    chk("addi_u2", 64'(out_uses_rs2), 64'd0);
    chk("addi_count", 64'(count), 64'd1);

    // lui, beq, sw streamed through with out_ready high
    out_ready = 1; in_valid = 1;
    in_instr = 32'h123452B7; in_pc = 32'h44; cyc();
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    chk("lui_rd", 64'(out_rd), 64'd5);
    in_instr = 32'hFE208EE3; in_pc = 32'h48; cyc();
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("beq_wr", 64'(out_writes_rd), 64'd0);
    chk("beq_rd", 64'(out_rd), 64'd0);
    in_instr = 32'h0020A423; in_pc = 32'h4C; cyc();
    chk("sw_imm", 64'(out_imm), 64'h8);
    chk("sw_rs2", 64'(out_rs2), 64'd2);
    chk("sw_wr", 64'(out_writes_rd), 64'd0);
    in_valid = 0; cyc();

    // Fill past capacity with out_ready low, then drain; fetch holds each word
    // until accepted so all six must come out.
    for (int i = 0; i < 6; i++) words[i] = rand_instr();
    out_ready = 0; k = 0; delivered = 0;
    repeat (6) begin
      in_valid = (k < 6); in_instr = words[k % 6]; in_pc = 32'h100 + 32'(4 * k);
      if (in_valid && q.size() < DEPTH) begin cyc(); k++; end else cyc();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    out_ready = 1; guard = 0;
    while (delivered < 6 && guard < 50) begin
      in_valid = (k < 6); in_instr = words[k % 6]; in_pc = 32'h100 + 32'(4 * k);
      if (in_valid && q.size() < DEPTH) begin cyc(); k++; end else cyc();
      guard++;
    end
    in_valid = 0;
    chk("six_delivered", 64'(delivered), 64'd6);

    // Fill to 4, then push and pop together across the wrap
    out_ready = 0; in_valid = 1; guard = 0;
    while (q.size() < DEPTH && guard < 10) begin
      in_instr = rand_instr(); in_pc = $urandom; cyc(); guard++;
    end
    chk("refill_count", 64'(count), 64'd4);
    out_ready = 1;
    repeat (8) begin
      in_instr = rand_instr(); in_pc = $urandom; cyc();
      chk("osc_range", 64'(count == 3 || count == 4), 64'd1);
    end

    // Flush at count 3 with a concurrent push and pop
    in_valid = 0; out_ready = 0;
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1; in_valid = 1; out_ready = 1; in_instr = 32'h00000013; in_pc = 32'hBAD;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(); cyc();
    chk("flush_no_ghost", 64'(out_valid), 64'd0);

    // Illegal words are queued and delivered in order
    out_ready = 0; in_valid = 1;
    in_instr = 32'h00000000; in_pc = 32'h200; cyc();
    in_instr = 32'hFFFFFFFF; in_pc = 32'h204; cyc();
    in_valid = 0;
    chk("ill0_illegal", 64'(out_illegal), 64'd1);
    chk("ill0_flags", 64'({out_uses_rs1, out_uses_rs2, out_writes_rd}), 64'd0);
    out_ready = 1; cyc();
    chk("ill1_pc", 64'(out_pc), 64'h204);
    chk("ill1_illegal", 64'(out_illegal), 64'd1);
    chk("ill1_flags", 64'({out_uses_rs1, out_uses_rs2, out_writes_rd}), 64'd0);
    cyc();

    // Randomized traffic
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      cyc();
    end
    flush = 0;

    // Asynchronous reset mid-stream
    out_ready = 0; in_valid = 1;
    repeat (3) begin in_instr = rand_instr(); in_pc = $urandom; cyc(); end
    in_valid = 0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    q.delete();
    @(posedge clk); #1; rst = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
